// File: rtl/bitmask_index_encoder.sv
// bitmask_index_encoder
//   Accepts a WIDTH-bit mask and serially emits the index of every set bit,
//   lowest index first. One mask is held at a time; valid/ready on both sides.
//
//   State table:
//     state | meaning
//     IDLE  | waiting for a mask; in_ready=1 once out of reset
//     EMIT  | presenting lowest set bit of pending_q; out_valid=busy=1
//
//   Ports:
//     clk, rst_n        rising-edge clock, async active-low reset
//     in_valid/in_ready input handshake, in_vec is the mask
//     out_valid/out_ready output handshake, out_idx = lowest remaining bit,
//                       out_last = that bit is the final one of the mask
//     zero_drop         one-cycle pulse after an all-zero mask is accepted
//     busy              high while in EMIT
module bitmask_index_encoder #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_drop,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             in_ready_q, in_ready_d;
    logic             zero_drop_q, zero_drop_d;

    logic [IDX_W-1:0] low_idx;
    logic [WIDTH-1:0] pending_rest;
    logic             single_bit;

    // Lowest set bit; scanning downward lets the lowest index win.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // x & (x-1) strips the lowest set bit; empty remainder means one bit left.
    assign pending_rest = pending_q & (pending_q - WIDTH'(1));
    assign single_bit   = (pending_q != '0) && (pending_rest == '0);

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        in_ready_d  = in_ready_q;
        zero_drop_d = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    if (in_vec != '0) begin
                        pending_d  = in_vec;
                        state_d    = EMIT;
                        in_ready_d = 1'b0;
                    end else begin
                        zero_drop_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                in_ready_d = 1'b0;
                if (out_ready) begin
                    if (single_bit) begin
                        pending_d  = '0;
                        state_d    = IDLE;
                        in_ready_d = 1'b1;
                    end else begin
                        pending_d = pending_rest;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                pending_d  = '0;
                in_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            in_ready_q  <= 1'b0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            in_ready_q  <= in_ready_d;
            zero_drop_q <= zero_drop_d;
        end
    end

    // All outputs come straight from registers (or a decode of pending_q),
    // so they stay stable under backpressure and reset to 0 with pending_q.
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign out_idx   = low_idx;
    assign out_last  = single_bit;
    assign zero_drop = zero_drop_q;

endmodule

// File: doc/bitmask_index_encoder.md
Name: bitmask_index_encoder

Overview:
- Inverse of the register-file one-hot decoder: accepts a 32-bit bit-mask (one-hot or multi-hot) and serially emits the 5-bit index of every set bit, lowest index first.
- Used wherever a write-enable/valid mask must be turned back into register numbers, e.g. multi-register commit/writeback sequencing and scoreboard clear.
- Valid/ready handshake on both the input and output sides. Holds one mask at a time.

Parameters:
- WIDTH, 32, mask width; must equal 2**IDX_W.
- IDX_W, 5, index width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_vec is presented.
- in_ready  output  1  block can accept a mask.
- in_vec  input  WIDTH  bit-mask to encode.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer accepts out_idx.
- out_idx  output  IDX_W  index of the lowest remaining set bit.
- out_last  output  1  out_idx is the final set bit of the current mask.
- zero_drop  output  1  one-cycle pulse: an all-zero mask was accepted and discarded.
- busy  output  1  a mask is being emitted (state EMIT).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, zero_drop=0, busy=0, in_ready=0. in_ready goes to 1 on the first cycle after rst_n deasserts.
- State IDLE:
  - in_ready=1, out_valid=0.
  - Accept occurs on a clock edge where in_valid && in_ready.
  - Accept with in_vec!=0: pending<=in_vec, go to EMIT.
  - Accept with in_vec==0: stay in IDLE, zero_drop=1 for exactly the next cycle, no output produced.
- State EMIT:
  - in_ready=0, busy=1, out_valid=1.
  - out_idx = position of the lowest set bit of pending.
  - out_last = 1 when pending has exactly one bit set.
  - out_idx and out_last are decoded only from registered state. They never change while out_valid && !out_ready.
  - Handshake (out_valid && out_ready at an edge): clear bit out_idx in pending.
  - If out_last was 1 at that handshake, go to IDLE with pending=0.
- Latency:
  - Accept at edge N: out_valid=1 in the cycle after edge N.
  - Each handshake at edge M presents the next index in the cycle after M. With out_ready held high, this gives one index per cycle.
  - The final handshake at edge M returns in_ready=1 in the cycle after M. No input bypass, so there is at least one cycle of in_ready=1 between the last output of one mask and the first output of the next.
- Boundaries:
  - Mask 0xFFFFFFFF produces 32 outputs, 0..31. out_last is set only on 31.
  - Bit 31 alone produces idx=31, last=1.
  - in_vec is sampled only at accept. Changes to in_vec during EMIT are ignored.
  - out_ready has no effect in IDLE.
  - in_valid has no effect in EMIT; the mask is not accepted and must be held by the producer.
- Reset mid-EMIT: the remaining bits are discarded immediately and asynchronously, with outputs at their reset values. No partial output appears after reset.
- No X on any output after reset. The index is fully defined for every pending!=0.

Test Plan:
- Single bit: reset, in_vec=0x00000001 accepted -> next cycle out_valid=1, out_idx=0, out_last=1. After the handshake, in_ready=1 and busy=0.
- Multi-hot with out_ready=1: in_vec=0x80000005 -> outputs 0, 2, 31 on consecutive cycles. out_last=1 only with 31. in_ready=0 throughout, then 1 the cycle after.
- Backpressure: in_vec=0x00000300, out_ready=0 for 3 cycles -> out_idx=8, out_last=0 held stable. Raise out_ready -> 8 then 9 (last=1).
- Full mask: in_vec=0xFFFFFFFF, out_ready=1 -> exactly 32 handshakes, indices 0..31 ascending. A new in_valid during emission is not accepted.
- Zero mask: in_vec=0 accepted -> zero_drop=1 for one cycle, out_valid stays 0, in_ready stays 1.
- Reset mid-operation: in_vec=0x0000F000, assert rst_n=0 after the first handshake (idx 12) -> out_valid=0 and busy=0 immediately. After release: in_ready=1, and a new mask 0x00000010 yields idx=4, last=1.
